wb_host_initiator: RTL

- Wishbone classic single-transfer initiator (bus master) for the user project area.
- It is the counterpart to the Wishbone responders that hang off the management-side bus.
- Converts a valid/ready command stream (from an LA-driven or internal controller) into one Wishbone read or write cycle per command.
- Returns read data and completion status on a valid/ready response stream; a bus timeout prevents a hung responder from stalling the controller.

---
 rtl/wb_host_initiator.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/wb_host_initiator.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle out, one response back.
// Optional macro WB_HOST_INITIATOR_ERR_EN adds a wbm_err_i input that terminates a cycle with an error.
module wb_host_initiator #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
`ifdef WB_HOST_INITIATOR_ERR_EN
    input  logic        wbm_err_i,
`endif
    input  logic        wbm_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Terminal count: the cycle is abandoned once the counter has reached this value.
    localparam logic [TO_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state, state_next;
    logic [TO_W-1:0] to_cnt, to_cnt_next;

    logic            cmd_ready_next;
    logic            cyc_next;
    logic            stb_next;
    logic            we_next;
    logic [31:0]     adr_next;
    logic [31:0]     dat_next;
    logic [3:0]      sel_next;
    logic            rsp_valid_next;
    logic [31:0]     rsp_dat_next;
    logic            rsp_err_next;

    logic            bus_err;
    logic            timeout_hit;

`ifdef WB_HOST_INITIATOR_ERR_EN
    assign bus_err = wbm_err_i;
`else
    assign bus_err = 1'b0;
`endif

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= IDLE;
            to_cnt      <= '0;
            cmd_ready_o <= 1'b0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            wbm_sel_o   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            state       <= state_next;
            to_cnt      <= to_cnt_next;
            cmd_ready_o <= cmd_ready_next;
            wbm_cyc_o   <= cyc_next;
            wbm_stb_o   <= stb_next;
            wbm_we_o    <= we_next;
            wbm_adr_o   <= adr_next;
            wbm_dat_o   <= dat_next;
            wbm_sel_o   <= sel_next;
            rsp_valid_o <= rsp_valid_next;
            rsp_dat_o   <= rsp_dat_next;
            rsp_err_o   <= rsp_err_next;
        end
    end

    // Every output is registered, so this block computes the value each one takes after the next edge.
    always_comb begin
        state_next     = state;
        to_cnt_next    = to_cnt;
        cmd_ready_next = 1'b0;
        cyc_next       = wbm_cyc_o;
        stb_next       = wbm_stb_o;
        we_next        = wbm_we_o;
        adr_next       = wbm_adr_o;
        dat_next       = wbm_dat_o;
        sel_next       = wbm_sel_o;
        rsp_valid_next = rsp_valid_o;
        rsp_dat_next   = rsp_dat_o;
        rsp_err_next   = rsp_err_o;

        case (state)
            IDLE: begin
                cmd_ready_next = 1'b1;
                if (cmd_valid_i && cmd_ready_o) begin
                    we_next        = cmd_we_i;
                    adr_next       = cmd_adr_i;
                    dat_next       = cmd_dat_i;
                    sel_next       = cmd_sel_i;
                    cyc_next       = 1'b1;
                    stb_next       = 1'b1;
                    to_cnt_next    = '0;
                    cmd_ready_next = 1'b0;
                    state_next     = BUS;
                end
            end

            // ERR beats ACK beats timeout when they land on the same edge.
            BUS: begin
                if (bus_err || wbm_ack_i || timeout_hit) begin
                    cyc_next       = 1'b0;
                    stb_next       = 1'b0;
                    rsp_valid_next = 1'b1;
                    state_next     = RESP;
                    if (!bus_err && wbm_ack_i) begin
                        rsp_err_next = 1'b0;
                        rsp_dat_next = wbm_we_o ? 32'd0 : wbm_dat_i;
                    end else begin
                        rsp_err_next = 1'b1;
                        rsp_dat_next = 32'd0;
                    end
                end else if (to_cnt != '1) begin
                    to_cnt_next = to_cnt + 1'b1;
                end
            end

            // cmd_ready only rises after the handshake edge, forcing one idle bus cycle.
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_next = 1'b0;
                    cmd_ready_next = 1'b1;
                    state_next     = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
